memory_controller: RTL and testbench
====================================

# memory_controller

- Sits between the byte-wide system RAM/IO bus and the CPU's two memory clients: instruction fetch and the load/store buffer (LSB).
- Arbitrates between the two clients and turns each 1/2/4-byte request into a byte-serial RAM access sequence.
- Returns assembled little-endian words with a one-cycle done pulse.
- Aborts speculative reads on misprediction clear, but always completes committed stores.

## Interface
- REG_WIDTH, 32, address/data word width
- IO_ADDR_HI, 32'h0003_0000, base of IO space; addresses with bits [31:16] == 16'h0003 are IO

- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  pause when low: all state frozen, mem_wr forced 0
- clear_signal  input  1  misprediction flush
- io_buffer_full  input  1  UART output buffer full
- mem_din  input  8  RAM read byte, valid one cycle after its address
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write this cycle
- if_signal  input  1  fetch request, held until if_done
- if_addr  input  32  fetch address, 4 bytes
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word
- lsb_signal  input  1  LSB request, held until lsb_done
- lsb_wr  input  1  1 = store
- lsb_len  input  2  0: 1 byte, 1: 2 bytes, 2/3: 4 bytes
- lsb_addr  input  32  byte address
- lsb_dout  input  32  store data, low bytes used
- lsb_din  output  32  load data, zero-extended
- lsb_done  output  1  one-cycle pulse

## Operation
- States: IDLE, READ, WRITE, DONE.
- Byte counter cnt: 3 bits. Length n: 1, 2 or 4. Fetch always uses n = 4.
- Active-client register: IF or LSB. Fairness bit last_lsb.
- IDLE, arbitration:
  - Both clients requesting: LSB wins if last_lsb == 0, otherwise IF wins.
  - Only one requesting: that client wins.
  - On grant: latch addr, wr, n and data; set cnt = 0; set last_lsb = (winner is LSB).
  - Go to WRITE for a store, READ otherwise.
- READ:
  - Drive mem_a = base + cnt while cnt < n.
  - From the second READ cycle on, shift mem_din into byte lane cnt-1.
  - After byte n-1 is captured, go to DONE.
  - Done pulse for the active client (if_done/lsb_done) with its data register is registered on the DONE-entry edge.
- WRITE:
  - Each cycle drive mem_wr = 1, mem_a = base + cnt, mem_dout = byte cnt; then cnt++.
  - If the address is IO and io_buffer_full == 1: mem_wr = 0, cnt held, retry next cycle.
  - After byte n-1, go to DONE with lsb_done pulse.
- DONE:
  - Single cycle; ignores requests, because the client drops its signal on the done edge.
  - Then go to IDLE.
- clear_signal in READ (either client) or in IDLE: next state IDLE, no done pulse, mem_wr = 0.
- clear_signal in WRITE or DONE: ignored; a committed store always completes.
- Address arithmetic wraps mod 2^32.
- Unused upper bytes of lsb_din are 0. Sign extension is the consumer's job.
- Reset values: state IDLE, last_lsb 0, mem_wr 0, mem_a 0, mem_dout 0, if_done 0, lsb_done 0, if_data 0, lsb_din 0.

## Timing
- Request to first RAM cycle: 1 cycle (grant edge).
- Read of n bytes: n+1 READ cycles, then the done pulse. Fetch: request sampled at cycle t, if_done high at cycle t+6.
- Write of n bytes: n cycles plus IO stall cycles, then lsb_done.
- Done pulses are exactly 1 cycle. Back-to-back requests are separated by the DONE cycle.
- rdy_in low stretches every phase with no lost or duplicated bytes.
- Reset asserted mid-access: all outputs go to reset values immediately; no partial done.

## Structure
- Shared header/package: REG_WIDTH, length codes (LEN_B = 0, LEN_H = 1, LEN_W = 2), IO_ADDR_HI, state encoding.
- Single module; arbitration and byte steering inline. No sub-module needed.

## Test plan
- Fetch from RAM with bytes 0x13,0x05,0x00,0x00 at 0x1000 -> if_done at t+6, if_data = 32'h0000_0513, mem_wr never 1.
- LSB store len=1, addr 0x2003, data 0xAABBCCDD -> one write cycle with mem_a = 0x2003, mem_dout = 0xDD; lsb_done 2 cycles after request.
- IF and LSB request together twice in a row -> grants LSB then IF. The second simultaneous pair grants IF first.
- Halfword load from 0x3000 (bytes 0x34,0x12) with clear asserted after the first byte -> no lsb_done, state IDLE next cycle, new fetch accepted.
- Word store to IO 0x30000 with io_buffer_full high for 3 cycles mid-store -> mem_wr low for those cycles; all 4 bytes written exactly once, in order.
- rdy_in low for 2 cycles during a word load -> lsb_din correct, done delayed by exactly 2 cycles.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Imported by the bus interface and the controller itself.
package memory_controller_pkg;

  localparam int REG_WIDTH = 32;
  localparam logic [REG_WIDTH-1:0] IO_ADDR_HI = 32'h0003_0000;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    CL_IF,
    CL_LSB
  } client_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [REG_WIDTH-1:0] addr);
    return addr[31:16] == IO_ADDR_HI[31:16];
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// RAM/IO byte bus plus the fetch and load/store client handshakes.
// master = controller side, slave = RAM and CPU clients.
interface memory_controller_if;
  import memory_controller_pkg::*;

  logic                 io_buffer_full;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [REG_WIDTH-1:0] mem_a;
  logic                 mem_wr;

  logic                 if_signal;
  logic [REG_WIDTH-1:0] if_addr;
  logic                 if_done;
  logic [REG_WIDTH-1:0] if_data;

  logic                 lsb_signal;
  logic                 lsb_wr;
  logic [1:0]           lsb_len;
  logic [REG_WIDTH-1:0] lsb_addr;
  logic [REG_WIDTH-1:0] lsb_dout;
  logic [REG_WIDTH-1:0] lsb_din;
  logic                 lsb_done;

  modport master (
    input  io_buffer_full, mem_din,
    input  if_signal, if_addr,
    input  lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_dout,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data, lsb_din, lsb_done
  );

  modport slave (
    output io_buffer_full, mem_din,
    output if_signal, if_addr,
    output lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_dout,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data, lsb_din, lsb_done
  );

endinterface

// File: rtl/memory_controller.sv
// Arbitrates fetch and LSB requests and runs each as a byte-serial RAM access,
// returning little-endian words with a one-cycle done pulse.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_signal,
  memory_controller_if.master bus
);

  state_t               state_reg, state_next;
  client_t              client_reg, client_next;
  logic [2:0]           cnt_reg, cnt_next;
  logic [2:0]           n_reg, n_next;
  logic                 last_lsb_reg, last_lsb_next;
  logic [REG_WIDTH-1:0] base_reg, base_next;
  logic [REG_WIDTH-1:0] data_reg, data_next;
  logic [REG_WIDTH-1:0] if_data_reg, if_data_next;
  logic [REG_WIDTH-1:0] lsb_din_reg, lsb_din_next;
  logic                 if_done_reg, if_done_next;
  logic                 lsb_done_reg, lsb_done_next;

  logic [REG_WIDTH-1:0] byte_addr, hold_addr, rd_word, mem_a_c;
  logic [7:0]           mem_dout_c;
  logic                 mem_wr_c, grant_lsb, wr_stall, capture;
  logic [2:0]           lane_idx;

  assign byte_addr = base_reg + {29'd0, cnt_reg};
  // While paused, keep presenting the previous address so mem_din still
  // carries the byte that has not been captured yet when rdy_in returns.
  assign hold_addr = (rdy_in || cnt_reg == 3'd0) ? byte_addr : byte_addr - 32'd1;
  assign capture   = (state_reg == S_READ) && (cnt_reg != 3'd0);
  assign lane_idx  = cnt_reg - 3'd1;
  assign grant_lsb = bus.lsb_signal && (!bus.if_signal || !last_lsb_reg);
  assign wr_stall  = is_io(byte_addr) && bus.io_buffer_full;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_word[8*gi +: 8] = (capture && lane_idx == 3'(gi)) ? bus.mem_din
                                                                   : data_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    client_next   = client_reg;
    cnt_next      = cnt_reg;
    n_next        = n_reg;
    last_lsb_next = last_lsb_reg;
    base_next     = base_reg;
    data_next     = data_reg;
    if_data_next  = if_data_reg;
    lsb_din_next  = lsb_din_reg;
    if_done_next  = 1'b0;
    lsb_done_next = 1'b0;
    mem_a_c       = '0;
    mem_dout_c    = '0;
    mem_wr_c      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!clear_signal && (bus.if_signal || bus.lsb_signal)) begin
          cnt_next      = 3'd0;
          last_lsb_next = grant_lsb;
          if (grant_lsb) begin
            client_next = CL_LSB;
            base_next   = bus.lsb_addr;
            n_next      = len_bytes(bus.lsb_len);
            data_next   = bus.lsb_wr ? bus.lsb_dout : '0;
            state_next  = bus.lsb_wr ? S_WRITE : S_READ;
          end else begin
            client_next = CL_IF;
            base_next   = bus.if_addr;
            n_next      = 3'd4;
            data_next   = '0;
            state_next  = S_READ;
          end
        end
      end

      S_READ: begin
        if (!rdy_in || cnt_reg < n_reg) begin
          mem_a_c = hold_addr;
        end
        data_next = rd_word;
        if (clear_signal) begin
          state_next = S_IDLE;
        end else if (cnt_reg == n_reg) begin
          state_next = S_DONE;
          if (client_reg == CL_IF) begin
            if_done_next = 1'b1;
            if_data_next = rd_word;
          end else begin
            lsb_done_next = 1'b1;
            lsb_din_next  = rd_word;
          end
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end

      S_WRITE: begin
        mem_a_c    = byte_addr;
        mem_dout_c = data_reg[{cnt_reg[1:0], 3'b000} +: 8];
        mem_wr_c   = !wr_stall;
        if (!wr_stall) begin
          if (cnt_reg == n_reg - 3'd1) begin
            state_next    = S_DONE;
            lsb_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= S_IDLE;
      client_reg   <= CL_IF;
      cnt_reg      <= '0;
      n_reg        <= '0;
      last_lsb_reg <= 1'b0;
      base_reg     <= '0;
      data_reg     <= '0;
      if_data_reg  <= '0;
      lsb_din_reg  <= '0;
      if_done_reg  <= 1'b0;
      lsb_done_reg <= 1'b0;
    end else if (rdy_in) begin
      state_reg    <= state_next;
      client_reg   <= client_next;
      cnt_reg      <= cnt_next;
      n_reg        <= n_next;
      last_lsb_reg <= last_lsb_next;
      base_reg     <= base_next;
      data_reg     <= data_next;
      if_data_reg  <= if_data_next;
      lsb_din_reg  <= lsb_din_next;
      if_done_reg  <= if_done_next;
      lsb_done_reg <= lsb_done_next;
    end
  end

  assign bus.mem_a    = mem_a_c;
  assign bus.mem_dout = mem_dout_c;
  assign bus.mem_wr   = mem_wr_c && rdy_in;
  assign bus.if_done  = if_done_reg;
  assign bus.if_data  = if_data_reg;
  assign bus.lsb_done = lsb_done_reg;
  assign bus.lsb_din  = lsb_din_reg;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: byte RAM model, write log and done counters,
// one task per scenario plus a randomized sweep against a word-level model.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear_signal = 1'b0;

  memory_controller_if bus();

  memory_controller dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // RAM model: byte per address (low 16 bits), read data one cycle after address
  logic [7:0]  ram [0:65535];
  logic        fill_req = 1'b0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [31:0] wlog_a [0:4095];
  logic [7:0]  wlog_d [0:4095];
  int          wlog_n = 0;
  int          if_done_cnt = 0;
  int          lsb_done_cnt = 0;

  always @(posedge clk_in) begin
    if (fill_req) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end
    if (bus.mem_wr) begin
      if (wlog_n < 4096) begin
        wlog_a[wlog_n] <= bus.mem_a;
        wlog_d[wlog_n] <= bus.mem_dout;
      end
      wlog_n <= wlog_n + 1;
      if (!is_io(bus.mem_a)) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.if_done)  if_done_cnt  <= if_done_cnt + 1;
    if (bus.lsb_done) lsb_done_cnt <= lsb_done_cnt + 1;
  end

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] w;
    logic [31:0] a;
    w = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      w[8*i +: 8] = ram[a[15:0]];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic start_req(input bit is_lsb, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] data);
    if (is_lsb) begin
      bus.lsb_signal = 1'b1;
      bus.lsb_wr     = wr;
      bus.lsb_len    = len;
      bus.lsb_addr   = addr;
      bus.lsb_dout   = data;
    end else begin
      bus.if_signal = 1'b1;
      bus.if_addr   = addr;
    end
  endtask

  // Counts cycles from the request cycle to the visible done pulse (-1 on timeout)
  task automatic wait_done(input bit is_lsb, input bit rand_rdy, output int lat, output int paused);
    lat = -1;
    paused = 0;
    for (int c = 1; c <= 200; c++) begin
      if (rand_rdy) begin
        rdy_in = ($urandom_range(0, 3) != 0);
        if (!rdy_in) paused++;
      end
      tick();
      if (is_lsb ? bus.lsb_done : bus.if_done) begin
        lat = c;
        break;
      end
    end
    rdy_in = 1'b1;
    if (is_lsb) bus.lsb_signal = 1'b0;
    else        bus.if_signal  = 1'b0;
  endtask

  task automatic wait_any(output bit got_if, output bit got_lsb);
    got_if = 1'b0;
    got_lsb = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.if_done || bus.lsb_done) begin
        got_if = bus.if_done;
        got_lsb = bus.lsb_done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); end
    checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", bus.mem_a); end
    checks++; if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", bus.mem_dout); end
    checks++; if ({bus.if_done, bus.lsb_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", {bus.if_done, bus.lsb_done}); end
    checks++; if ({bus.if_data, bus.lsb_din} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bus.if_data, bus.lsb_din}); end
    rst_in = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_arbitration();
    logic [31:0] a1, a2, a3, e1, e2, e3;
    bit gif, glsb;
    int lat, p;
    a1 = 32'($urandom_range(0, 16'hFF00));
    a2 = 32'($urandom_range(0, 16'hFF00));
    a3 = 32'($urandom_range(0, 16'hFF00));
    e1 = model_read(a1, 4);
    e2 = model_read(a2, 4);
    e3 = model_read(a3, 2);
    start_req(1'b1, 1'b0, LEN_W, a1, 32'h0);
    start_req(1'b0, 1'b0, LEN_W, a2, 32'h0);
    wait_any(gif, glsb);
    checks++; if ({gif, glsb} !== 2'b01) begin errors++; $display("FAIL arb_first_lsb: got if/lsb=%b expected 01", {gif, glsb}); end
    checks++; if (bus.lsb_din !== e1) begin errors++; $display("FAIL arb_lsb_data: got %h expected %h", bus.lsb_din, e1); end
    bus.lsb_signal = 1'b0;
    tick();
    start_req(1'b1, 1'b0, LEN_H, a3, 32'h0);
    wait_any(gif, glsb);
    checks++; if ({gif, glsb} !== 2'b10) begin errors++; $display("FAIL arb_second_if: got if/lsb=%b expected 10", {gif, glsb}); end
    checks++; if (bus.if_data !== e2) begin errors++; $display("FAIL arb_if_data: got %h expected %h", bus.if_data, e2); end
    bus.if_signal = 1'b0;
    wait_done(1'b1, 1'b0, lat, p);
    checks++; if (lat < 1 || bus.lsb_din !== e3) begin errors++; $display("FAIL arb_third_lsb: got %h lat=%0d expected %h", bus.lsb_din, lat, e3); end
    tick();
    $display("arbitration: lsb %h, if %h, lsb %h", a1, a2, a3);
  endtask

  task automatic test_fetch();
    int lat, p, w0;
    poke(16'h1000, 8'h13);
    poke(16'h1001, 8'h05);
    poke(16'h1002, 8'h00);
    poke(16'h1003, 8'h00);
    w0 = wlog_n;
    start_req(1'b0, 1'b0, LEN_W, 32'h1000, 32'h0);
    wait_done(1'b0, 1'b0, lat, p);
    checks++; if (lat != 6) begin errors++; $display("FAIL fetch_latency: got %0d expected 6", lat); end
    checks++; if (bus.if_data !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data: got %h expected 00000513", bus.if_data); end
    tick();
    checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b expected 0", bus.if_done); end
    checks++; if (wlog_n != w0) begin errors++; $display("FAIL fetch_no_write: got %0d writes expected 0", wlog_n - w0); end
    $display("fetch: addr 00001000 data %h lat %0d", bus.if_data, lat);
  endtask

  task automatic test_store_byte();
    int lat, p, w0;
    w0 = wlog_n;
    start_req(1'b1, 1'b1, LEN_B, 32'h2003, 32'hAABB_CCDD);
    wait_done(1'b1, 1'b0, lat, p);
    tick();
    checks++; if (lat != 2) begin errors++; $display("FAIL store_b_latency: got %0d expected 2", lat); end
    checks++; if (wlog_n - w0 != 1) begin errors++; $display("FAIL store_b_count: got %0d expected 1", wlog_n - w0); end
    checks++; if (wlog_a[w0] !== 32'h2003 || wlog_d[w0] !== 8'hDD) begin errors++; $display("FAIL store_b_byte: got %h/%h expected 00002003/dd", wlog_a[w0], wlog_d[w0]); end
    $display("store byte: addr 00002003 lat %0d", lat);
  endtask

  task automatic test_clear();
    int lat, p, c0;
    poke(16'h3000, 8'h34);
    poke(16'h3001, 8'h12);
    c0 = lsb_done_cnt;
    start_req(1'b1, 1'b0, LEN_H, 32'h3000, 32'h0);
    tick();
    tick();
    clear_signal = 1'b1;
    tick();
    clear_signal = 1'b0;
    bus.lsb_signal = 1'b0;
    checks++; if (bus.mem_a !== 32'h0 || bus.lsb_done !== 1'b0) begin errors++; $display("FAIL clear_idle: got mem_a=%h lsb_done=%b expected 0/0", bus.mem_a, bus.lsb_done); end
    start_req(1'b0, 1'b0, LEN_W, 32'h1000, 32'h0);
    wait_done(1'b0, 1'b0, lat, p);
    checks++; if (lat != 6 || bus.if_data !== 32'h0000_0513) begin errors++; $display("FAIL clear_refetch: got lat=%0d data=%h expected 6/00000513", lat, bus.if_data); end
    tick();
    checks++; if (lsb_done_cnt != c0) begin errors++; $display("FAIL clear_no_done: got %0d pulses expected 0", lsb_done_cnt - c0); end
    $display("clear: load aborted, refetch lat %0d", lat);
  endtask

  task automatic test_io_stall();
    logic [31:0] d;
    int lat, p, w0;
    d = $urandom;
    w0 = wlog_n;
    start_req(1'b1, 1'b1, LEN_W, 32'h0003_0000, d);
    tick();
    tick();
    bus.io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL io_stall_wr%0d: got %b expected 0", k, bus.mem_wr); end
      tick();
    end
    bus.io_buffer_full = 1'b0;
    wait_done(1'b1, 1'b0, lat, p);
    tick();
    checks++; if (lat + 5 != 8) begin errors++; $display("FAIL io_latency: got %0d expected 8", lat + 5); end
    checks++; if (wlog_n - w0 != 4) begin errors++; $display("FAIL io_count: got %0d expected 4", wlog_n - w0); end
    for (int i = 0; i < 4 && i < wlog_n - w0; i++) begin
      checks++;
      if (wlog_a[w0+i] !== 32'h0003_0000 + 32'(i) || wlog_d[w0+i] !== d[8*i +: 8]) begin
        errors++;
        $display("FAIL io_byte%0d: got %h/%h expected %h/%h", i, wlog_a[w0+i], wlog_d[w0+i], 32'h0003_0000 + 32'(i), d[8*i +: 8]);
      end
    end
    $display("io store: data %h lat %0d", d, lat + 5);
  endtask

  task automatic test_rdy_pause();
    logic [31:0] a, e;
    int lat, p;
    a = 32'($urandom_range(0, 16'hFF00));
    e = model_read(a, 4);
    start_req(1'b1, 1'b0, LEN_W, a, 32'h0);
    tick();
    tick();
    rdy_in = 1'b0;
    tick();
    tick();
    rdy_in = 1'b1;
    wait_done(1'b1, 1'b0, lat, p);
    tick();
    checks++; if (lat + 4 != 8) begin errors++; $display("FAIL pause_latency: got %0d expected 8", lat + 4); end
    checks++; if (bus.lsb_din !== e) begin errors++; $display("FAIL pause_data: got %h expected %h", bus.lsb_din, e); end
    $display("rdy pause: addr %h data %h", a, bus.lsb_din);
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int lat, p, w0;
    e = model_read(32'hFFFF_FFFE, 4);
    start_req(1'b0, 1'b0, LEN_W, 32'hFFFF_FFFE, 32'h0);
    wait_done(1'b0, 1'b0, lat, p);
    tick();
    checks++; if (bus.if_data !== e) begin errors++; $display("FAIL wrap_fetch: got %h expected %h", bus.if_data, e); end
    w0 = wlog_n;
    start_req(1'b1, 1'b1, LEN_H, 32'hFFFF_FFFF, 32'h0000_BEEF);
    wait_done(1'b1, 1'b0, lat, p);
    tick();
    checks++;
    if (wlog_n - w0 != 2 || wlog_a[w0] !== 32'hFFFF_FFFF || wlog_a[w0+1] !== 32'h0 || wlog_d[w0] !== 8'hEF || wlog_d[w0+1] !== 8'hBE) begin
      errors++;
      $display("FAIL wrap_store: got n=%0d %h/%h %h/%h expected 2 ffffffff/ef 00000000/be",
               wlog_n - w0, wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1]);
    end
    $display("wrap: fetch %h, halfword store across zero", bus.if_data);
  endtask

  task automatic test_random();
    bit          is_lsb, wr;
    logic [1:0]  len;
    logic [31:0] addr, d, e, got;
    int n, lat, p, w0, ci, cl, exp_lat;
    for (int it = 0; it < 40; it++) begin
      is_lsb = 1'($urandom_range(0, 1));
      wr     = is_lsb && 1'($urandom_range(0, 1));
      len    = is_lsb ? 2'($urandom_range(0, 3)) : LEN_W;
      n      = nbytes(len);
      addr   = 32'($urandom_range(0, 65535));
      d      = $urandom;
      e      = model_read(addr, n);
      w0 = wlog_n;
      ci = if_done_cnt;
      cl = lsb_done_cnt;
      start_req(is_lsb, wr, len, addr, d);
      wait_done(is_lsb, 1'b1, lat, p);
      got = is_lsb ? bus.lsb_din : bus.if_data;
      tick();
      exp_lat = (wr ? n + 1 : n + 2) + p;
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, exp_lat); end
      if (wr) begin
        checks++; if (wlog_n - w0 != n) begin errors++; $display("FAIL rnd%0d_wcount: got %0d expected %0d", it, wlog_n - w0, n); end
        for (int i = 0; i < n && i < wlog_n - w0; i++) begin
          checks++;
          if (wlog_a[w0+i] !== addr + 32'(i) || wlog_d[w0+i] !== d[8*i +: 8]) begin
            errors++;
            $display("FAIL rnd%0d_wbyte%0d: got %h/%h expected %h/%h", it, i, wlog_a[w0+i], wlog_d[w0+i], addr + 32'(i), d[8*i +: 8]);
          end
        end
      end else begin
        checks++; if (got !== e) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", it, got, e); end
      end
      checks++;
      if ((is_lsb ? lsb_done_cnt - cl : if_done_cnt - ci) != 1 || (is_lsb ? if_done_cnt - ci : lsb_done_cnt - cl) != 0) begin
        errors++;
        $display("FAIL rnd%0d_pulses: got if=%0d lsb=%0d expected exactly one on the active client", it, if_done_cnt - ci, lsb_done_cnt - cl);
      end
      $display("txn %0d: lsb=%0b wr=%0b n=%0d addr=%h lat=%0d paused=%0d", it, is_lsb, wr, n, addr, lat, p);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_req(1'b0, 1'b0, LEN_W, 32'($urandom_range(0, 16'hFF00)), 32'h0);
    tick();
    tick();
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0 || bus.if_done !== 1'b0 || bus.if_data !== 32'h0 || bus.lsb_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got mem_a=%h wr=%b done=%b if_data=%h lsb_din=%h expected all 0",
               bus.mem_a, bus.mem_wr, bus.if_done, bus.if_data, bus.lsb_din);
    end
    bus.if_signal = 1'b0;
    d0 = if_done_cnt;
    tick();
    rst_in = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (if_done_cnt != d0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", if_done_cnt - d0); end
    $display("reset mid-fetch: outputs cleared");
  endtask

  initial begin
    bus.if_signal      = 1'b0;
    bus.if_addr        = '0;
    bus.lsb_signal     = 1'b0;
    bus.lsb_wr         = 1'b0;
    bus.lsb_len        = '0;
    bus.lsb_addr       = '0;
    bus.lsb_dout       = '0;
    bus.io_buffer_full = 1'b0;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;

    test_reset();
    test_arbitration();
    test_fetch();
    test_store_byte();
    test_clear();
    test_io_stall();
    test_rdy_pause();
    test_wrap();
    test_random();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
